ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/mem_pkg.sv | 15 +
 rtl/ram_array.sv | 25 ++
 rtl/ram_responder.sv | 117 +++++++++++
 tb/tb_ram_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the ram_responder slice.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH = 26;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 1024;
    localparam int CNT_WIDTH      = 4;

endpackage

// File: rtl/ram_array.sv
// Word storage: synchronous write, combinational read, never reset.
module ram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ram_responder.sv
// Wait-state memory responder: captures one request, waits WAIT_CYCLES,
// then acknowledges for one cycle, driving the shared bus on reads.
module ram_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    output logic                  ack,
    output logic                  err,
    output logic                  busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   we_q, we_d;

    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   bus_drive;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a < ADDR_WIDTH'(DEPTH);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        wr_en   = 1'b0;
        wr_idx  = addr_q[IDX_W-1:0];
        wr_data = data_q;
        case (state_q)
            IDLE: begin
                if (cs && (we || oe)) begin
                    addr_d = addr;
                    data_d = data;
                    we_d   = we;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the capture edge is also the ACK entry edge,
                        // so the write must use the live bus rather than the latches.
                        state_d = ACK;
                        wr_en   = we && in_range(addr);
                        wr_idx  = addr[IDX_W-1:0];
                        wr_data = data;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_WIDTH'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ACK;
                    wr_en   = we_q && in_range(addr_q);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    // Storage has no reset, so an edge seen while rst is high must not write.
    ram_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en && !rst),
        .wr_idx (wr_idx),
        .wr_data(wr_data),
        .rd_idx (addr_q[IDX_W-1:0]),
        .rd_data(rd_data)
    );

    assign ack       = (state_q == ACK);
    assign busy      = (state_q != IDLE);
    assign err       = ack && !in_range(addr_q);
    assign bus_drive = ack && !we_q && oe && !rst;
    assign data      = bus_drive ? (in_range(addr_q) ? rd_data : '0) : 'z;

endmodule

// File: tb/tb_ram_responder.sv
// Three responders (0, 1 and 3 wait states) on shared controls, checked
// every cycle against a transaction-level model plus literal spot checks.
module tb_ram_responder;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int N     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cs = 1'b0, we = 1'b0, oe = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] drv = '0;
    wire  [DW-1:0] bus0, bus1, bus2;
    logic [N-1:0]  ack, err, busy;

    assign bus0 = we ? drv : 'z;
    assign bus1 = we ? drv : 'z;
    assign bus2 = we ? drv : 'z;

    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus0), .cs(cs), .we(we), .oe(oe),
        .ack(ack[0]), .err(err[0]), .busy(busy[0]));
    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus1), .cs(cs), .we(we), .oe(oe),
        .ack(ack[1]), .err(err[1]), .busy(busy[1]));
    ram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus2), .cs(cs), .we(we), .oe(oe),
        .ack(ack[2]), .err(err[2]), .busy(busy[2]));

    wire [N-1:0] dut_drv = {dut2.bus_drive, dut1.bus_drive, dut0.bus_drive};

    function automatic int wc(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: k = cycles since capture (-1 idle); ack cycle is k == WAIT+1.
    int            k [N] = '{-1, -1, -1};
    bit            mw [N];
    logic [AW-1:0] ma [N];
    logic [DW-1:0] md [N];
    logic [DW-1:0] mem_m [N][DEPTH];
    bit            known [N][DEPTH];
    int            edge_n = 0;
    int            cap_edge [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) k[i] = -1;
        end else begin
            edge_n++;
            for (int i = 0; i < N; i++) begin
                if (k[i] >= 1) begin
                    if (k[i] == wc(i) + 1) k[i] = -1;
                    else k[i]++;
                end else if (cs && (we || oe)) begin
                    k[i] = 1; mw[i] = we; ma[i] = addr; md[i] = drv; cap_edge[i] = edge_n;
                end
                if (k[i] == wc(i) + 1 && mw[i] && ma[i] < DEPTH) begin
                    mem_m[i][ma[i][9:0]] = md[i];
                    known[i][ma[i][9:0]] = 1'b1;
                end
            end
        end
    end

    logic [DW-1:0] last_rd [N];
    int            last_lat [N];
    logic          last_err [N];
    int            ack_cnt [N] = '{0, 0, 0};
    int            prev_ack_edge = -1;
    bit            stream = 1'b0;
    logic [DW-1:0] bv;
    bit            ea, ed;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            bv = (i == 0) ? bus0 : (i == 1) ? bus1 : bus2;
            if (rst) begin
                chk($sformatf("rst_ack%0d", i), ack[i], 0);
                chk($sformatf("rst_busy%0d", i), busy[i], 0);
                chk($sformatf("rst_err%0d", i), err[i], 0);
                chk($sformatf("rst_drv%0d", i), dut_drv[i], 0);
            end else begin
                ea = (k[i] == wc(i) + 1);
                ed = ea && !mw[i] && oe;
                chk($sformatf("ack%0d", i), ack[i], ea);
                chk($sformatf("busy%0d", i), busy[i], k[i] >= 1);
                chk($sformatf("drive%0d", i), dut_drv[i], ed);
                if (ea) begin
                    chk($sformatf("err%0d", i), err[i], ma[i] >= DEPTH);
                    last_err[i] = err[i];
                    last_lat[i] = edge_n - cap_edge[i] + 1;
                    ack_cnt[i]++;
                    if (i == 1 && stream) begin
                        if (prev_ack_edge >= 0) chk("stream_gap", edge_n - prev_ack_edge, 3);
                        prev_ack_edge = edge_n;
                    end
                end
                if (ed) begin
                    last_rd[i] = bv;
                    if (ma[i] >= DEPTH) chk($sformatf("rd_oor%0d", i), bv, 0);
                    else if (known[i][ma[i][9:0]]) chk($sformatf("rd%0d", i), bv, mem_m[i][ma[i][9:0]]);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(k[0] < 0 && k[1] < 0 && k[2] < 0) && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 60) chk("idle_timeout", 0, 1);
    endtask

    task automatic req(input bit w, input bit o, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_idle();
        cs = 1'b1; we = w; oe = o; addr = a; drv = d;
        @(negedge clk); #1;
        cs = 1'b0; we = 1'b0;
        wait_idle();
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("pulse_ack%0d", i), ack[i], 0);
            chk($sformatf("pulse_busy%0d", i), busy[i], 0);
            chk($sformatf("pulse_drv%0d", i), dut_drv[i], 0);
        end
        #2 rst = 1'b0;
    endtask

    int  snap;
    bit  forbid;
    int  n_wait;

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Basic write then read; latency per wait-state setting.
        req(1, 0, 'h100, 32'h1000011E);
        req(0, 1, 'h100, 0);
        chk("lit_rd_100", last_rd[1], 32'h1000011E);
        chk("lit_err_100", last_err[1], 0);
        chk("lit_lat_w0", last_lat[0], 1);
        chk("lit_lat_w1", last_lat[1], 2);
        chk("lit_lat_w3", last_lat[2], 4);

        // Out-of-range accesses.
        req(1, 0, 0, 32'hA5);
        req(1, 0, AW'(DEPTH), 32'hDEAD);
        chk("lit_err_wr_oor", last_err[1], 1);
        req(0, 1, AW'(DEPTH), 0);
        chk("lit_err_rd_oor", last_err[1], 1);
        chk("lit_rd_oor", last_rd[1], 0);
        req(0, 1, 0, 0);
        chk("lit_addr0", last_rd[2], 32'hA5);

        // Reset during WAIT aborts the write on the waiting responders.
        req(1, 0, 'h11A, 32'h0BADF00D);
        cs = 1'b1; we = 1'b1; oe = 1'b0; addr = 'h11A; drv = 32'h78000009;
        @(negedge clk); #1;
        cs = 1'b0; we = 1'b0;
        rst_pulse();
        req(0, 1, 'h11A, 0);
        chk("lit_abort_w1", last_rd[1], 32'h0BADF00D);
        chk("lit_abort_w3", last_rd[2], 32'h0BADF00D);
        chk("lit_commit_w0", last_rd[0], 32'h78000009);

        // we and oe together is a write.
        req(1, 1, 'h104, 32'h5);
        req(0, 1, 'h104, 0);
        chk("lit_weoe_w1", last_rd[1], 32'h5);
        chk("lit_weoe_w3", last_rd[2], 32'h5);

        // Back-to-back reads with cs/oe held.
        for (int j = 0; j < 17; j++) req(1, 0, AW'('h100 + 2 * j), 32'hC0DE0000 + j);
        wait_idle();
        snap = ack_cnt[1];
        stream = 1'b1;
        cs = 1'b1; oe = 1'b1; we = 1'b0;
        for (int j = 0; j < 17; j++) begin
            addr = AW'('h100 + 2 * j);
            n_wait = 0;
            do begin
                @(negedge clk); #1;
                n_wait++;
            end while (k[1] != 1 && n_wait < 20);
            if (n_wait >= 20) chk("stream_timeout", 0, 1);
        end
        cs = 1'b0;
        wait_idle();
        stream = 1'b0;
        chk("lit_stream_acks", ack_cnt[1] - snap, 17);
        chk("lit_stream_last", last_rd[1], 32'hC0DE0010);

        // Random traffic, with occasional mid-cycle reset pulses.
        for (int it = 0; it < 1500; it++) begin
            forbid = 1'b0;
            for (int i = 0; i < N; i++)
                if (k[i] >= 1 && !mw[i] && (k[i] == wc(i) || k[i] == wc(i) + 1)) forbid = 1'b1;
            cs = ($urandom % 4) != 0;
            oe = $urandom % 2;
            we = forbid ? 1'b0 : 1'($urandom % 2);
            drv = $urandom;
            case ($urandom % 8)
                0, 1, 2, 3, 4, 5: addr = AW'('h100 + $urandom % 16);
                6:                addr = AW'(1020 + $urandom % 8);
                default:          addr = AW'($urandom);
            endcase
            if ($urandom % 80 == 0) rst_pulse();
            @(negedge clk); #1;
        end
        cs = 1'b0; we = 1'b0; oe = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
